// File: rtl/texture_buffer_pkg.sv
// Shared definitions for the texture buffer: size codes, load FSM states, size-code decode.
package texture_buffer_pkg;

  localparam logic [3:0] TEX_SIZE_32  = 4'd1;
  localparam logic [3:0] TEX_SIZE_64  = 4'd2;
  localparam logic [3:0] TEX_SIZE_128 = 4'd3;
  localparam logic [3:0] TEX_SIZE_256 = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } load_state_t;

  // Returns the edge log2 for a size code, or 0 when the code is not a texture size.
  function automatic logic [3:0] size_code_to_log2(input logic [3:0] code);
    case (code)
      TEX_SIZE_32:  return 4'd5;
      TEX_SIZE_64:  return 4'd6;
      TEX_SIZE_128: return 4'd7;
      TEX_SIZE_256: return 4'd8;
      default:      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/texture_buffer_ram.sv
// Two-bank texel RAM: one write port, one registered read port, bank select is the address MSB.
// Latency 1 on reads; no backpressure. The read register resets to zero, the array does not.
module texture_bank_ram #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge aclk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/texture_buffer.sv
// Double-buffered texel store: AXI-stream load into the back bank, 2-cycle S/T lookups from the front bank.
// tready is low only while a finished load waits for the bank swap. TEXTURE_CLAMP_EN selects clamp-to-edge.
module texture_buffer
  import texture_buffer_pkg::*;
#(
  parameter int MAX_SIZE_LOG2 = 8,
  parameter int TEXEL_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   s_texture_axis_tvalid,
  output logic                   s_texture_axis_tready,
  input  logic                   s_texture_axis_tlast,
  input  logic [TEXEL_WIDTH-1:0] s_texture_axis_tdata,
  input  logic [3:0]             confTextureMode,
  input  logic                   rasterizerRunning,
  input  logic                   texelValid,
  input  logic [15:0]            texelS,
  input  logic [15:0]            texelT,
  output logic [TEXEL_WIDTH-1:0] texelOut,
  output logic                   texelOutValid,
  output logic                   textureReady,
  output logic                   streamError,
  output logic [1:0]             dbgState
);

  localparam int IDX_W  = 2 * MAX_SIZE_LOG2;
  localparam int ADDR_W = IDX_W + 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [3:0] MAX_LOG2 = 4'(MAX_SIZE_LOG2);

  load_state_t      r_state;
  logic             r_tready;
  logic             r_bank;
  logic [3:0]       r_load_log2;
  logic [3:0]       r_front_log2;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_texture_ready;
  logic             r_stream_error;

  logic              w_accept;
  logic [3:0]        w_code_log2;
  logic              w_code_ok;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_texel_total;

  assign w_accept      = s_texture_axis_tvalid & r_tready;
  assign w_code_log2   = size_code_to_log2(confTextureMode);
  assign w_code_ok     = (w_code_log2 != 4'd0) && (w_code_log2 <= MAX_LOG2);
  assign w_cnt_inc     = r_count + CNT_W'(1);
  assign w_texel_total = CNT_W'(1) << {r_load_log2, 1'b0};

  // tready is registered from the next state, so it is already low in the first WAIT_SWAP cycle.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state         <= ST_IDLE;
      r_tready        <= 1'b0;
      r_bank          <= 1'b0;
      r_load_log2     <= 4'd5;
      r_front_log2    <= 4'd5;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_texture_ready <= 1'b0;
      r_stream_error  <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_load_log2 <= w_code_log2;
            r_count     <= CNT_W'(1);
            r_full      <= 1'b0;
            if (!w_code_ok) begin
              r_stream_error <= 1'b1;
              r_state        <= s_texture_axis_tlast ? ST_IDLE : ST_DRAIN;
            end else if (s_texture_axis_tlast) begin
              r_stream_error <= 1'b1;
              r_state        <= ST_WAIT_SWAP;
              r_tready       <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_count <= w_cnt_inc;
            if (w_cnt_inc == w_texel_total) begin
              r_full <= 1'b1;
            end
            if (s_texture_axis_tlast) begin
              if (w_cnt_inc != w_texel_total) begin
                r_stream_error <= 1'b1;
              end
              r_state  <= ST_WAIT_SWAP;
              r_tready <= 1'b0;
            end else if (w_cnt_inc == w_texel_total) begin
              r_stream_error <= 1'b1;
              r_state        <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept && s_texture_axis_tlast) begin
            if (r_full) begin
              r_state  <= ST_WAIT_SWAP;
              r_tready <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WAIT_SWAP: begin
          if (!rasterizerRunning) begin
            r_bank          <= ~r_bank;
            r_front_log2    <= r_load_log2;
            r_texture_ready <= 1'b1;
            r_state         <= ST_IDLE;
          end else begin
            r_tready <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;

  assign w_wr_en  = w_accept && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_wr_idx = (r_state == ST_IDLE) ? '0 : r_count[IDX_W-1:0];

  logic [3:0]               w_coord_shift;
  logic [MAX_SIZE_LOG2-1:0] w_s_wrap;
  logic [MAX_SIZE_LOG2-1:0] w_t_wrap;
  logic [MAX_SIZE_LOG2-1:0] w_s_int;
  logic [MAX_SIZE_LOG2-1:0] w_t_int;
  logic [IDX_W-1:0]         w_lookup_idx;

  // The top frontLog2 fraction bits of the 1.15 coordinate form the texel index.
  assign w_coord_shift = 4'd15 - r_front_log2;
  assign w_s_wrap      = MAX_SIZE_LOG2'(texelS[14:0] >> w_coord_shift);
  assign w_t_wrap      = MAX_SIZE_LOG2'(texelT[14:0] >> w_coord_shift);

`ifdef TEXTURE_CLAMP_EN
  logic [MAX_SIZE_LOG2-1:0] w_edge_max;
  assign w_edge_max = MAX_SIZE_LOG2'((16'd1 << r_front_log2) - 16'd1);
  assign w_s_int    = texelS[15] ? w_edge_max : w_s_wrap;
  assign w_t_int    = texelT[15] ? w_edge_max : w_t_wrap;
`else
  logic w_unused_coord_msb;
  assign w_unused_coord_msb = texelS[15] | texelT[15];
  assign w_s_int = w_s_wrap;
  assign w_t_int = w_t_wrap;
`endif

  assign w_lookup_idx = (IDX_W'(w_t_int) << r_front_log2) | IDX_W'(w_s_int);

  logic              r_rd_vld;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_out_vld;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_rd_vld  <= texelValid;
      r_rd_addr <= {r_bank, w_lookup_idx};
      r_out_vld <= r_rd_vld;
    end
  end

  texture_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (TEXEL_WIDTH)
  ) u_ram (
    .aclk      (aclk),
    .resetn    (resetn),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({~r_bank, w_wr_idx}),
    .i_wr_data (s_texture_axis_tdata),
    .i_rd_en   (r_rd_vld),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (texelOut)
  );

  assign s_texture_axis_tready = r_tready;
  assign texelOutValid         = r_out_vld;
  assign textureReady          = r_texture_ready;
  assign streamError           = r_stream_error;
  assign dbgState              = r_state;

endmodule

// File: tb/tb_texture_buffer.sv
// Directed bench for texture_buffer: loads, swap deferral, stream errors, clamp/wrap, reset mid-load.
`timescale 1ns/1ps
module tb_texture_buffer;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_texture_axis_tvalid = 1'b0;
  logic        s_texture_axis_tready;
  logic        s_texture_axis_tlast = 1'b0;
  logic [15:0] s_texture_axis_tdata = '0;
  logic [3:0]  confTextureMode = '0;
  logic        rasterizerRunning = 1'b0;
  logic        texelValid = 1'b0;
  logic [15:0] texelS = '0;
  logic [15:0] texelT = '0;
  logic [15:0] texelOut;
  logic        texelOutValid;
  logic        textureReady;
  logic        streamError;
  logic [1:0]  dbgState;

  int n_checks = 0;
  int n_errors = 0;

  texture_buffer #(.MAX_SIZE_LOG2(8), .TEXEL_WIDTH(16)) dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .s_texture_axis_tvalid (s_texture_axis_tvalid),
    .s_texture_axis_tready (s_texture_axis_tready),
    .s_texture_axis_tlast  (s_texture_axis_tlast),
    .s_texture_axis_tdata  (s_texture_axis_tdata),
    .confTextureMode       (confTextureMode),
    .rasterizerRunning     (rasterizerRunning),
    .texelValid            (texelValid),
    .texelS                (texelS),
    .texelT                (texelT),
    .texelOut              (texelOut),
    .texelOutValid         (texelOutValid),
    .textureReady          (textureReady),
    .streamError           (streamError),
    .dbgState              (dbgState)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    int n = 0;
    s_texture_axis_tvalid = 1'b1;
    s_texture_axis_tdata  = d;
    s_texture_axis_tlast  = last;
    while (!s_texture_axis_tready && n < 200) begin
      tick();
      n++;
    end
    if (!s_texture_axis_tready) check_val("tready_timeout", 32'(s_texture_axis_tready), 32'd1);
    tick();
  endtask

  task automatic send_range(input int base, input int first, input int last_i, input logic with_last);
    for (int i = first; i <= last_i; i++) begin
      send_beat(16'(base + i), with_last && (i == last_i));
    end
  endtask

  task automatic end_stream();
    s_texture_axis_tvalid = 1'b0;
    s_texture_axis_tlast  = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [15:0] s, input logic [15:0] t, input logic [15:0] exp);
    texelS = s;
    texelT = t;
    texelValid = 1'b1;
    tick();
    texelValid = 1'b0;
    tick();
    check_val({tag, "_vld"}, 32'(texelOutValid), 32'd1);
    check_val(tag, 32'(texelOut), 32'(exp));
  endtask

  task automatic settle();
    tick();
    tick();
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    tick();
    tick();
    check_val("rst_tready", 32'(s_texture_axis_tready), 32'd0);
    check_val("rst_texel_out", 32'(texelOut), 32'd0);
    check_val("rst_out_vld", 32'(texelOutValid), 32'd0);
    check_val("rst_ready", 32'(textureReady), 32'd0);
    check_val("rst_err", 32'(streamError), 32'd0);
    check_val("rst_state", 32'(dbgState), 32'd0);
    resetn = 1'b1;
    tick();
    check_val("tready_after_rst", 32'(s_texture_axis_tready), 32'd1);

    // Valid strobe tracks the request with 2 cycles latency even with no texture loaded
    texelValid = 1'b1;
    tick();
    texelValid = 1'b0;
    check_val("lat_not_early", 32'(texelOutValid), 32'd0);
    tick();
    check_val("lat_vld_no_tex", 32'(texelOutValid), 32'd1);
    tick();
    check_val("lat_vld_drop", 32'(texelOutValid), 32'd0);

    // 32x32 load, tdata = index
    confTextureMode = 4'd1;
    send_range(0, 0, 1023, 1'b1);
    end_stream();
    settle();
    check_val("t32_ready", 32'(textureReady), 32'd1);
    check_val("t32_err", 32'(streamError), 32'd0);
    check_val("t32_state", 32'(dbgState), 32'd0);
    lookup("t32_s1", 16'h0400, 16'h0000, 16'h0001);
    lookup("t32_corner", 16'h7C00, 16'h7C00, 16'd1023);

    // 64x64 load held off by the rasterizer; data offset 0x4000 to tell the banks apart
    rasterizerRunning = 1'b1;
    confTextureMode = 4'd2;
    send_range(16'h4000, 0, 4095, 1'b1);
    end_stream();
    tick();
    check_val("defer_state", 32'(dbgState), 32'd3);
    check_val("defer_tready", 32'(s_texture_axis_tready), 32'd0);
    lookup("defer_old", 16'h0400, 16'h0000, 16'h0001);
    for (int i = 0; i < 50; i++) tick();
    check_val("defer_state_50", 32'(dbgState), 32'd3);
    check_val("defer_tready_50", 32'(s_texture_axis_tready), 32'd0);
    rasterizerRunning = 1'b0;
    texelS = 16'h0000;
    texelT = 16'h0200;
    texelValid = 1'b1;
    tick();
    tick();
    check_val("swap_cycle_old", 32'(texelOut), 32'h0000);
    texelValid = 1'b0;
    tick();
    check_val("after_swap_new", 32'(texelOut), 32'h4040);
    check_val("after_swap_state", 32'(dbgState), 32'd0);
    check_val("after_swap_tready", 32'(s_texture_axis_tready), 32'd1);

    // Short 64x64 stream: partial texture still swapped in
    confTextureMode = 4'd2;
    send_range(16'h1000, 0, 99, 1'b1);
    end_stream();
    settle();
    check_val("short_err", 32'(streamError), 32'd1);
    check_val("short_ready", 32'(textureReady), 32'd1);
    check_val("short_state", 32'(dbgState), 32'd0);
    lookup("short_lookup", 16'h0400, 16'h0000, 16'h1002);

    // Reset in the middle of a load
    confTextureMode = 4'd1;
    send_range(16'h6000, 0, 499, 1'b0);
    end_stream();
    resetn = 1'b0;
    tick();
    check_val("midrst_tready", 32'(s_texture_axis_tready), 32'd0);
    check_val("midrst_ready", 32'(textureReady), 32'd0);
    check_val("midrst_state", 32'(dbgState), 32'd0);
    resetn = 1'b1;
    tick();
    send_range(16'h2000, 0, 1023, 1'b1);
    end_stream();
    settle();
    check_val("reload_ready", 32'(textureReady), 32'd1);
    check_val("reload_err", 32'(streamError), 32'd0);
    lookup("reload_s1", 16'h0400, 16'h0000, 16'h2001);

`ifdef TEXTURE_CLAMP_EN
    lookup("clamp_s", 16'h8400, 16'h0000, 16'h201F);
    lookup("clamp_t", 16'h0000, 16'h8000, 16'h23E0);
`else
    lookup("wrap_s", 16'h8400, 16'h0000, 16'h2001);
    lookup("wrap_t", 16'h0000, 16'h8000, 16'h2000);
`endif

    // Invalid size code: error, back to IDLE, front texture untouched
    confTextureMode = 4'd7;
    send_range(16'h5000, 0, 2, 1'b1);
    end_stream();
    settle();
    check_val("inval_err", 32'(streamError), 32'd1);
    check_val("inval_state", 32'(dbgState), 32'd0);
    check_val("inval_ready", 32'(textureReady), 32'd1);
    lookup("inval_front", 16'h0400, 16'h0000, 16'h2001);

    // Overlong 32x32 stream: 6 extra beats drained
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check_val("rst2_err", 32'(streamError), 32'd0);
    confTextureMode = 4'd1;
    send_range(16'h3000, 0, 1023, 1'b0);
    check_val("over_drain_state", 32'(dbgState), 32'd2);
    check_val("over_drain_err", 32'(streamError), 32'd1);
    send_range(16'h3000, 1024, 1029, 1'b1);
    end_stream();
    settle();
    check_val("over_ready", 32'(textureReady), 32'd1);
    check_val("over_state", 32'(dbgState), 32'd0);
    lookup("over_last", 16'h7C00, 16'h7C00, 16'h33FF);
    lookup("over_first", 16'h0000, 16'h0000, 16'h3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
